uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate in bits/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries; power of two, >= 2.
REQ-004 SHALL have port i_clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_data  input  8  byte to transmit.
REQ-007 SHALL have port i_valid  input  1  i_data is presented for write.
REQ-008 SHALL have port o_ready  output  1  buffer can accept a byte this cycle.
REQ-009 SHALL have port o_tx  output  1  serial line; idle high; registered.
REQ-010 SHALL have port o_busy  output  1  a frame is in progress.
REQ-011 SHALL have port o_count  output  $clog2(FIFO_DEPTH)+1  bytes held in the buffer, excluding the frame in flight.

Function
REQ-012 SHALL use CLKS_PER_BIT = CLK_FREQ / BAUD with integer truncation; every line bit, including start and stop, SHALL last exactly CLKS_PER_BIT cycles.
REQ-013 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-014 SHALL accept a byte on a rising edge when i_valid=1 and o_ready=1; i_valid while o_ready=0 SHALL be ignored, with no buffer or count change.
REQ-015 SHALL drive o_ready = (o_count < FIFO_DEPTH), combinationally from the count only; a pop in the same cycle SHALL NOT make a full buffer ready.
REQ-016 SHALL implement the buffer as a circular FIFO with read/write pointers wrapping modulo FIFO_DEPTH; bytes SHALL be transmitted in acceptance order.
REQ-017 SHALL update o_count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: o_tx=1, o_busy=0; if o_count>0, pop one byte into a shift register, load the bit counter, drive o_tx=0 and enter START on the same edge.
REQ-020 A byte accepted on edge N into an empty buffer with the FSM in IDLE SHALL be popped on edge N+1, so o_tx goes low on edge N+1.
REQ-021 START: after CLKS_PER_BIT cycles, enter DATA with o_tx = bit 0.
REQ-022 DATA: every CLKS_PER_BIT cycles, advance one bit; after bit 7's period, enter STOP with o_tx=1.
REQ-023 STOP: after CLKS_PER_BIT cycles, pop and enter START on that same edge if o_count>0; otherwise enter IDLE. No idle cycles SHALL occur between back-to-back frames.
REQ-024 o_busy SHALL be 1 in START, DATA and STOP.
REQ-025 The in-flight byte SHALL be held in the shift register; buffer pushes during a frame SHALL NOT alter it.
REQ-026 Any illegal FSM encoding SHALL return to IDLE with o_tx=1 on the next edge.

Reset
REQ-027 While i_rst=1, outputs SHALL be o_tx=1, o_busy=0, o_count=0, o_ready=1; FSM IDLE, pointers and counters 0. Buffer data contents need not be cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), discard all buffered bytes, and drive the line high.
REQ-029 After reset deasserts, the first accepted byte SHALL be transmitted as specified in REQ-020.

Verification (CLK_FREQ=50000000, BAUD=5000000 -> 10 cycles/bit, FIFO_DEPTH=4 unless stated)
REQ-030 Push a single byte 0x41 while idle -> o_tx low from the next edge, then line sequence 0,1,0,0,0,0,0,1,0,1, 10 cycles each; o_busy high exactly 100 cycles, then IDLE.
REQ-031 Hold i_valid with bytes 0x10..0x15 presented back-to-back -> o_ready drops when o_count=4; every accepted byte is transmitted in order with each stop bit immediately followed by the next start bit; o_count returns to 0.
REQ-032 Push while o_count=4 -> o_count stays 4; the offered byte never appears on o_tx.
REQ-033 Assert i_rst during data bit 3 with 2 bytes buffered -> o_tx=1, o_busy=0, o_count=0 immediately; after release, push 0x5A -> a clean 0x5A frame is transmitted.
REQ-034 Bytes 0x00 and 0xFF -> line low for 90 cycles then high 10; low 10 cycles then high 90.
REQ-035 BAUD=4500000 -> CLKS_PER_BIT=11; every bit measures exactly 11 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a circular transmit FIFO
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [7:0]                   i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic                         o_tx,
    output logic                         o_busy,
    output logic [$clog2(FIFO_DEPTH):0]  o_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic bit_done;
    logic have_data;

    // Ready depends on the registered count only, so a full buffer stays
    // unready even in the cycle the transmitter pops from it.
    assign o_ready   = count_q < CNT_FULL;
    assign push      = i_valid & o_ready;
    assign have_data = count_q != '0;
    assign bit_done  = baud_cnt_q == BAUD_LAST;

    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign o_count = count_q;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_done ? '0 : baud_cnt_q + BAUD_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                if (have_data) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when bytes wait.
                    if (have_data) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_idx_d = '0;
                        tx_d      = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule
